// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states and
// fetch constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      PCS_SEQ    = 2'b00,
      PCS_BRANCH = 2'b01,
      PCS_REG    = 2'b10,
      PCS_JUMP   = 2'b11
   } pcsource_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_REQ   = 2'b01,
      S_HOLD  = 2'b10,
      S_DRAIN = 2'b11
   } fetch_state_e;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/inst_fetch_npc_mux.sv
// Next-PC selector: sequential PC+4 or one of the branch, register and jump
// targets. Targets pass through unmodified.
import cpu_pkg::*;

module npc_mux (
   input  logic [1:0]  pcsource,
   input  logic [31:0] pc4,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic [31:0] npc
);

   always_comb begin
      npc = pc4;
      case (pcsource_e'(pcsource))
         PCS_BRANCH: npc = bpc;
         PCS_REG:    npc = rpc;
         PCS_JUMP:   npc = jpc;
         default:    npc = pc4;
      endcase
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, imem handshake FSM and IF/ID register.
// Define INST_FETCH_PERF_CNT_EN to add fetch_cnt / stall_cnt counters.
import cpu_pkg::*;

module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] id_Inst,
   output logic [31:0] id_pc4,
   output logic        id_valid
`ifdef INST_FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  pc4_q, pc4_d;
   logic         valid_q, valid_d;
   logic [31:0]  hold_inst_q, hold_inst_d;
   logic [31:0]  hold_pc4_q, hold_pc4_d;
   logic [31:0]  drain_addr_q, drain_addr_d;
   logic [31:0]  pc4, npc;
   logic         redirect;
   logic         fetch_load, stall_tick;

   assign pc4      = pc_q + PC_INC;
   assign redirect = (pcsource_e'(pcsource) != PCS_SEQ);

   npc_mux u_npc_mux (
      .pcsource (pcsource),
      .pc4      (pc4),
      .bpc      (bpc),
      .rpc      (rpc),
      .jpc      (jpc),
      .npc      (npc)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      hold_inst_d  = hold_inst_q;
      hold_pc4_d   = hold_pc4_q;
      drain_addr_d = drain_addr_q;
      fetch_load   = 1'b0;
      stall_tick   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            stall_tick = !imem_ack;
            if (id_stall) begin
               if (imem_ack) begin
                  hold_inst_d = imem_rdata;
                  hold_pc4_d  = pc4;
                  state_d     = S_HOLD;
               end
            end else if (redirect) begin
               pc_d    = npc;
               inst_d  = NOP;
               valid_d = 1'b0;
               // Request still outstanding: keep it alive until memory answers.
               if (!imem_ack) begin
                  drain_addr_d = pc_q;
                  state_d      = S_DRAIN;
               end
            end else if (imem_ack) begin
               inst_d     = imem_rdata;
               pc4_d      = pc4;
               valid_d    = 1'b1;
               pc_d       = npc;
               fetch_load = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            stall_tick = 1'b1;
            if (!id_stall) begin
               state_d = S_REQ;
               pc_d    = npc;
               if (redirect) begin
                  inst_d  = NOP;
                  valid_d = 1'b0;
               end else begin
                  inst_d     = hold_inst_q;
                  pc4_d      = hold_pc4_q;
                  valid_d    = 1'b1;
                  fetch_load = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (!id_stall) begin
               valid_d = 1'b0;
               if (redirect) begin
                  pc_d   = npc;
                  inst_d = NOP;
               end
            end
            if (imem_ack) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= NOP;
         pc4_q        <= 32'h0;
         valid_q      <= 1'b0;
         hold_inst_q  <= NOP;
         hold_pc4_q   <= 32'h0;
         drain_addr_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         hold_inst_q  <= hold_inst_d;
         hold_pc4_q   <= hold_pc4_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   assign imem_req  = (state_q == S_REQ) || (state_q == S_DRAIN);
   assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   assign PC        = pc_q;
   assign id_Inst   = inst_q;
   assign id_pc4    = pc4_q;
   assign id_valid  = valid_q;

`ifdef INST_FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_load};
      stall_cnt_d = stall_cnt_q + {31'd0, stall_tick};
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = fetch_load ^ stall_tick;
`endif

endmodule
